// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: eight-digit multiplexed common-anode 7-segment driver.
// Time view hh-mm-ss, date view dd.mm.yyyy. All inputs are snapshotted once
// per frame so a frame never mixes old and new digits or views.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 12500
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       mode,
    input  logic [3:0] hr_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] sec_1s,
    input  logic [3:0] d_10s,
    input  logic [3:0] d_1s,
    input  logic [3:0] m_10s,
    input  logic [3:0] m_1s,
    input  logic [3:0] c_10s,
    input  logic [3:0] c_1s,
    input  logic [3:0] y_10s,
    input  logic [3:0] y_1s,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0]     r_pre;
    logic [2:0]        r_idx;
    logic              r_load_pend;
    logic              r_mode_q;
    logic [5:0][3:0]   r_tim;   // [5]=hr_10s .. [0]=sec_1s
    logic [7:0][3:0]   r_cal;   // [7]=d_10s  .. [0]=y_1s

    logic              w_tick;
    logic              w_load;
    logic [7:0]        w_an;
    logic [6:0]        w_seg;
    logic              w_dp;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] b);
        logic [6:0] s;
        unique case (b)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign w_tick = (r_pre == PW'(REFRESH_DIV - 1));
    // Snapshot shares its edge with the 7->0 wrap, so digit 0 is already fresh.
    assign w_load = r_load_pend || (w_tick && (r_idx == 3'd7));

    // Prescaler and digit index advance.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick)
                r_idx <= r_idx + 3'd1;
        end
    end

    // Per-frame snapshot of all digit inputs and the view mode.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_load_pend <= 1'b1;
            r_mode_q    <= 1'b0;
            r_tim       <= '0;
            r_cal       <= '0;
        end else if (w_load) begin
            r_load_pend <= 1'b0;
            r_mode_q    <= mode;
            r_tim       <= {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
            r_cal       <= {d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s};
        end
    end

    // Decode of the current digit slot from the snapshot.
    always_comb begin
        w_an  = ~(8'b1 << r_idx);
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (r_mode_q) begin
            w_seg = bcd_to_seg(r_cal[r_idx]);
            w_dp  = ~((r_idx == 3'd6) || (r_idx == 3'd4));
        end else begin
            unique case (r_idx)
                3'd7: w_seg = (r_tim[5] == 4'd0) ? SEG_BLANK : bcd_to_seg(r_tim[5]);
                3'd6: w_seg = bcd_to_seg(r_tim[4]);
                3'd5: w_seg = SEG_DASH;
                3'd4: w_seg = bcd_to_seg(r_tim[3]);
                3'd3: w_seg = bcd_to_seg(r_tim[2]);
                3'd2: w_seg = SEG_DASH;
                3'd1: w_seg = bcd_to_seg(r_tim[1]);
                3'd0: w_seg = bcd_to_seg(r_tim[0]);
                default: w_seg = SEG_BLANK;
            endcase
        end
    end

    // Registered display outputs; kept dark until the first snapshot exists.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (r_load_pend) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= w_seg;
            dp  <= w_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV = 4.
module tb_seg7_scan_driver;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [3:0] hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s;
    logic [3:0] d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n        = 0;

    // Hand-decoded segment patterns, indexed by digit idx 0..7.
    logic [6:0] t_time0 [8];   // 09:05:37
    logic [6:0] t_date  [8];   // 14.04.2022
    logic [6:0] t_time2 [8];   // 19:05:3C

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk_100MHz(clk), .reset(reset), .mode(mode),
        .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
        .sec_10s(sec_10s), .sec_1s(sec_1s),
        .d_10s(d_10s), .d_1s(d_1s), .m_10s(m_10s), .m_1s(m_1s),
        .c_10s(c_10s), .c_1s(c_1s), .y_10s(y_10s), .y_1s(y_1s),
        .an(an), .seg(seg), .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        check_eq($sformatf("%s an", tag), 32'(an), 32'(e_an));
        check_eq($sformatf("%s seg", tag), 32'(seg), 32'(e_seg));
        check_eq($sformatf("%s dp", tag), 32'(dp), 32'(e_dp));
    endtask

    initial begin
        t_time0[0] = 7'h78; t_time0[1] = 7'h30; t_time0[2] = 7'h3F; t_time0[3] = 7'h12;
        t_time0[4] = 7'h40; t_time0[5] = 7'h3F; t_time0[6] = 7'h10; t_time0[7] = 7'h7F;
        t_date[0]  = 7'h24; t_date[1]  = 7'h24; t_date[2]  = 7'h40; t_date[3]  = 7'h24;
        t_date[4]  = 7'h19; t_date[5]  = 7'h40; t_date[6]  = 7'h19; t_date[7]  = 7'h79;
        t_time2[0] = 7'h3F; t_time2[1] = 7'h30; t_time2[2] = 7'h3F; t_time2[3] = 7'h12;
        t_time2[4] = 7'h40; t_time2[5] = 7'h3F; t_time2[6] = 7'h10; t_time2[7] = 7'h79;

        reset = 1'b1;
        mode  = 1'b0;
        {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} = {4'd0, 4'd9, 4'd0, 4'd5, 4'd3, 4'd7};
        {d_10s, d_1s, m_10s, m_1s} = {4'd1, 4'd4, 4'd0, 4'd4};
        {c_10s, c_1s, y_10s, y_1s} = {4'd2, 4'd0, 4'd2, 4'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset_held", 8'hFF, 7'h7F, 1'b1);

        reset = 1'b0;
        n = 0;
        step();   // snapshot load edge
        // Output at edge n shows digit ((n-1)/4)%8 of frame (n-1)/32.
        for (int k = 2; k <= 117; k++) begin
            int unsigned d, f;
            logic [6:0] e_seg;
            logic       e_dp;
            step();
            d = ((n - 1) / 4) % 8;
            f = (n - 1) / 32;
            e_dp = 1'b1;
            if (f == 0)
                e_seg = t_time0[d];
            else if (f == 1) begin
                e_seg = t_date[d];
                e_dp  = ~((d == 6) || (d == 4));
            end else
                e_seg = t_time2[d];
            check_out($sformatf("n%0d_f%0d_d%0d", n, f, d), ~(8'b1 << d), e_seg, e_dp);
            // Mid-frame changes while digit 3 (frame 0) / digit 2 (frame 1) shows.
            if (n == 14) begin
                mode    = 1'b1;
                hr_10s  = 4'd1;
                sec_1s  = 4'hC;
            end
            if (n == 42)
                mode = 1'b0;
        end

        // Now showing digit 5 of frame 3; reset asynchronously between edges.
        #2 reset = 1'b1;
        #1 check_out("async_reset", 8'hFF, 7'h7F, 1'b1);
        step();
        step();
        check_out("reset_hold2", 8'hFF, 7'h7F, 1'b1);

        reset = 1'b0;
        n = 0;
        step();
        step();
        check_out("restart_idx0", 8'hFE, 7'h3F, 1'b1);
        step();
        step();
        check_out("restart_idx0_end", 8'hFE, 7'h3F, 1'b1);
        step();
        check_out("restart_idx1", 8'hFD, 7'h30, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Eight-digit, time-multiplexed seven-segment driver that sits directly downstream of the clock/calendar top level. It consumes the BCD digit outputs of the clock and calendar and drives the board's common-anode display (an/seg/dp, all active-low). A mode input selects between a time view (hh-mm-ss) and a date view (dd.mm.yyyy). Inputs and mode are snapshotted once per frame so a displayed frame is never torn by a mid-scan update.

## Interface

- REFRESH_DIV, default 12500: clk_100MHz cycles per digit slot (8 kHz digit rate, 1 kHz frame at 100 MHz); must be ≥ 2.

- clk_100MHz  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = time view, 1 = date view.
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  input  4 each  clock BCD digits.
- d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s  input  4 each  calendar BCD digits (c = century pair, y = year pair).
- an  output  8  digit anodes, active-low; an[0] = rightmost digit.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low.

## Operation

- Prescaler `pre` counts 0..REFRESH_DIV-1 and wraps; `tick` = (pre == REFRESH_DIV-1).
- Digit index `idx` (3 bits) increments on tick, wrapping 7→0. idx selects an[idx] (only that bit low).
- Snapshot registers hold all 14 digit inputs plus `mode_q`. They load on the edge where idx wraps 7→0, and on the first clock edge after reset deasserts (load-pending flag set by reset, cleared by that load).
- Time view, digits idx 7..0: hr_10s, hr_1s, dash, min_10s, min_1s, dash, sec_10s, sec_1s. hr_10s == 0 is blanked (leading-zero suppression). dp off on all digits.
- Date view, digits idx 7..0: d_10s, d_1s, m_10s, m_1s, c_10s, c_1s, y_10s, y_1s. No blanking. dp lit on idx 6 and idx 4 only.
- Decoder (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. BCD values 10–15 show a dash (0111111). Internal dash glyph is 0111111. Blank is 1111111.
- Changing mode or the digit inputs mid-frame has no visible effect until the next 7→0 wrap.

## Timing

- Reset values: an=8'hFF, seg=7'h7F, dp=1, pre=0, idx=0, snapshot=0, mode_q=0, load-pending=1.
- an/seg/dp are registered. They are the decode of the current (idx, snapshot, mode_q) and lag those by exactly one clock.
- First clock after reset release: snapshot loads. Second clock: outputs show digit idx 0 of the fresh snapshot.
- Each digit is displayed for exactly REFRESH_DIV cycles. A full frame is 8·REFRESH_DIV cycles.
- Snapshot load and idx 7→0 share an edge. Digit 0 of the new frame is therefore already decoded from the new snapshot.
- Reset asserted mid-frame returns all state to reset values immediately, regardless of the clock. The display is dark while reset is held.

## Test plan

- Reset: hold reset over several clocks → an=FF, seg=7F, dp=1. Release → an=FE one clock after snapshot load, then advances to an=FD after REFRESH_DIV cycles.
- Scan order (REFRESH_DIV=4): observe 32 cycles → anode sequence FE, FD, FB, F7, EF, DF, BF, 7F, each held 4 cycles, then repeats.
- Time view, inputs 09:05:37, mode=0 → idx7 blank (7F), idx6 '9' (0010000), idx5 and idx2 dash (0111111), idx4 '0', idx3 '5', idx1 '3', idx0 '7'; dp=1 throughout.
- Date view, inputs 14.04.2022, mode=1 → digits 1,4,0,4,2,0,2,2 on idx7..0; dp=0 only while an=BF or an=EF.
- Mid-frame change: toggle mode 0→1 while idx=3 → remaining digits of the frame stay in time view. Date view appears on the frame starting at the next 7→0 wrap.
- Invalid BCD: sec_1s=4'hC → idx0 shows dash (0111111). Separately, assert reset while idx=5 → outputs go to reset values asynchronously, and scanning restarts at idx 0.
